// File: rtl/pixel_cfg_pkg.sv
// Shared types and default sizing for the pixel config sweep checker.
package pixel_cfg_pkg;

    localparam int unsigned NPIX_DEF = 180;
    localparam int unsigned AW_DEF   = 8;
    localparam int unsigned DW_DEF   = 15;
    localparam int unsigned TMO_DEF  = 16;
    localparam int unsigned ECW_DEF  = 16;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_e;

    typedef enum logic [1:0] {M_INCR, M_WALK1, M_CONST, M_CHECK} mode_e;

endpackage

// File: rtl/pixel_cfg_pattern_gen.sv
// Combinational expected pixel config data for a given pattern mode, seed and address.
module pixel_cfg_pattern_gen
    import pixel_cfg_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  mode_e         mode,
    input  logic [DW-1:0] seed,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    logic [DW-1:0] addr_dw;
    int unsigned   bit_idx;

    always_comb begin
        addr_dw = DW'(addr);
        bit_idx = 32'(addr) % DW;
        unique case (mode)
            M_INCR:  data = seed + addr_dw;
            M_WALK1: data = DW'(1) << bit_idx;
            M_CONST: data = seed;
            M_CHECK: data = addr[0] ? ~seed : seed;
            default: data = seed;
        endcase
    end

endmodule

// File: rtl/pixel_cfg_sweep_checker.sv
// Sweeps all pixel addresses over the SPI cfg write path and checks each resulting pixel write.
module pixel_cfg_sweep_checker
    import pixel_cfg_pkg::*;
#(
    parameter int unsigned NPIX = NPIX_DEF,
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned TMO  = TMO_DEF,
    parameter int unsigned ECW  = ECW_DEF
) (
    input  logic            sys_clock,
    input  logic            sys_reset,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [DW-1:0]   seed,
    output logic [AW-1:0]   spi_cfg_addr,
    output logic [DW-1:0]   spi_cfg_data,
    output logic            spi_cfg_valid,
    input  logic [NPIX-1:0] pixel_sel,
    input  logic [DW-1:0]   pixel_wdata,
    input  logic            pixel_wren,
    output logic            busy,
    output logic            done,
    output logic [ECW-1:0]  err_cnt,
    output logic [AW-1:0]   first_err_addr,
    output logic            first_err_vld
);

    localparam int unsigned TW = $clog2(TMO + 1);

    state_e         state;
    mode_e          mode_q;
    logic [DW-1:0]  seed_q;
    logic [TW-1:0]  tmo_cnt;
    logic           tmo_hit;
    logic           sel_bad;
    logic           data_bad;
    logic           err_evt;
    logic           first_evt;

    pixel_cfg_pattern_gen #(
        .AW (AW),
        .DW (DW)
    ) u_pattern_gen (
        .mode (mode_q),
        .seed (seed_q),
        .addr (spi_cfg_addr),
        .data (spi_cfg_data)
    );

    assign tmo_hit  = (tmo_cnt == TW'(TMO - 1));
    assign sel_bad  = (pixel_sel != (NPIX'(1) << spi_cfg_addr));
    assign data_bad = (pixel_wdata != spi_cfg_data);

    // Spurious wren in IDLE/DONE counts but never claims first_err_*.
    always_comb begin
        err_evt   = 1'b0;
        first_evt = 1'b0;
        unique case (state)
            WAIT: begin
                err_evt   = pixel_wren ? (sel_bad || data_bad) : tmo_hit;
                first_evt = err_evt;
            end
            NEXT: begin
                err_evt   = pixel_wren;
                first_evt = pixel_wren;
            end
            IDLE, DONE: err_evt = pixel_wren && !start;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            state          <= IDLE;
            mode_q         <= M_INCR;
            seed_q         <= '0;
            tmo_cnt        <= '0;
            spi_cfg_addr   <= '0;
            spi_cfg_valid  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            first_err_vld  <= 1'b0;
        end else begin
            if (err_evt && (err_cnt != {ECW{1'b1}})) begin
                err_cnt <= err_cnt + ECW'(1);
            end
            if (first_evt && !first_err_vld) begin
                first_err_vld  <= 1'b1;
                first_err_addr <= spi_cfg_addr;
            end
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q         <= mode_e'(mode);
                        seed_q         <= seed;
                        spi_cfg_addr   <= '0;
                        err_cnt        <= '0;
                        first_err_addr <= '0;
                        first_err_vld  <= 1'b0;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                        spi_cfg_valid  <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    spi_cfg_valid <= 1'b0;
                    tmo_cnt       <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    // A wren coinciding with the last timeout cycle is a valid handshake.
                    if (pixel_wren || tmo_hit) begin
                        state <= NEXT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                NEXT: begin
                    if (spi_cfg_addr == AW'(NPIX - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        spi_cfg_addr  <= spi_cfg_addr + AW'(1);
                        spi_cfg_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
